// File: rtl/period_tracker.sv
// period_tracker: edge-pair half-period filter with ACQ/TRACK lock FSM and override.
// Define PERIOD_TRACKER_OUTLIER_EN to enable outlier rejection in TRACK.
module period_tracker #(
    parameter int W         = 12,
    parameter int G         = 8,
    parameter int ACQ_ALPHA = 1,
    parameter int LOCK_CNT  = 4,
    parameter int TOL_SH    = 2,
    parameter int MAX_REJ   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         edge_valid,
    input  logic [W-1:0] edge_rise,
    input  logic [W-1:0] edge_fall,
    input  logic [2:0]   alpha,
    input  logic         ovr_en,
    input  logic [W-1:0] ovr_period,
    output logic [W-1:0] r2f,
    output logic [W-1:0] f2r,
    output logic [W-1:0] eff_period,
    output logic         eff_valid,
    output logic         locked,
    output logic         outlier
);
    typedef enum logic {ACQ, TRACK} state_t;
    localparam logic [W-1:0] MID = W'(1) << (W - 1);

    state_t       state_q, state_d;
    logic [W-1:0] r2f_q, r2f_d, f2r_q, f2r_d;
    logic [3:0]   acq_cnt_q, acq_cnt_d;
    logic [2:0]   rej_cnt_q, rej_cnt_d;
    logic         eff_valid_q, eff_valid_d, locked_q, locked_d, outlier_q, outlier_d;
    logic         zero, is_r, out_en, out_c, force_acq, reject;
    logic [W-1:0] d, cur, dev, upd;
    logic [2:0]   a, a_acq;
    logic [W:0]   sum;

    // One-pole IIR step with rounding; saturates to all-ones on overflow.
    function automatic logic [W-1:0] filt(input logic [W-1:0] c, input logic [W-1:0] x, input logic [2:0] sh);
        logic [W+G:0] acc, nv;
        logic [W:0]   res;
        acc = {1'b0, c, {G{1'b0}}};
        nv  = ({1'b0, x, {G{1'b0}}} >> sh) + acc - (acc >> sh);
        res = {1'b0, nv[W+G-1:G]} + (W+1)'(nv[G-1]);
        return (nv[W+G] | res[W]) ? '1 : res[W-1:0];
    endfunction

`ifdef PERIOD_TRACKER_OUTLIER_EN
    assign out_en = 1'b1;
`else
    assign out_en = 1'b0;
`endif

    // Next-state: pick the half period, test for outliers, filter and step the lock FSM.
    always_comb begin
        zero        = (edge_rise == '0) && (edge_fall == '0);
        is_r        = edge_fall > edge_rise;
        d           = is_r ? edge_fall - edge_rise : edge_rise - edge_fall;
        cur         = is_r ? r2f_q : f2r_q;
        dev         = (d > cur) ? d - cur : cur - d;
        out_c       = out_en && (state_q == TRACK) && (dev > (cur >> TOL_SH));
        force_acq   = out_c && (rej_cnt_q == 3'(MAX_REJ - 1));
        reject      = out_c && !force_acq;
        a_acq       = (alpha > 3'(ACQ_ALPHA)) ? 3'(ACQ_ALPHA) : alpha;
        a           = force_acq ? 3'(ACQ_ALPHA) : (state_q == ACQ) ? a_acq : alpha;
        upd         = filt(cur, d, a);
        state_d     = state_q;
        r2f_d       = r2f_q;
        f2r_d       = f2r_q;
        acq_cnt_d   = acq_cnt_q;
        rej_cnt_d   = rej_cnt_q;
        eff_valid_d = 1'b0;
        outlier_d   = 1'b0;
        if (edge_valid) begin
            if (zero) begin
                r2f_d     = MID;
                f2r_d     = MID;
                state_d   = ACQ;
                acq_cnt_d = '0;
                rej_cnt_d = '0;
            end else if (reject) begin
                rej_cnt_d = rej_cnt_q + 3'd1;
                outlier_d = 1'b1;
            end else begin
                r2f_d       = is_r ? upd : r2f_q;
                f2r_d       = is_r ? f2r_q : upd;
                eff_valid_d = 1'b1;
                rej_cnt_d   = '0;
                if (force_acq) begin
                    state_d   = ACQ;
                    acq_cnt_d = '0;
                end else if (state_q == ACQ) begin
                    state_d   = (acq_cnt_q == 4'(LOCK_CNT - 1)) ? TRACK : ACQ;
                    acq_cnt_d = (acq_cnt_q == 4'(LOCK_CNT - 1)) ? 4'd0 : acq_cnt_q + 4'd1;
                end
            end
        end
        locked_d = (state_d == TRACK);
    end

    // State and registered outputs, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACQ;
            r2f_q       <= MID;
            f2r_q       <= MID;
            acq_cnt_q   <= '0;
            rej_cnt_q   <= '0;
            eff_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            outlier_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            r2f_q       <= r2f_d;
            f2r_q       <= f2r_d;
            acq_cnt_q   <= acq_cnt_d;
            rej_cnt_q   <= rej_cnt_d;
            eff_valid_q <= eff_valid_d;
            locked_q    <= locked_d;
            outlier_q   <= outlier_d;
        end
    end

    assign sum        = {1'b0, r2f_q} + {1'b0, f2r_q};
    assign eff_period = ovr_en ? ovr_period : (sum[W] ? '1 : sum[W-1:0]);
    assign r2f        = r2f_q;
    assign f2r        = f2r_q;
    assign eff_valid  = eff_valid_q;
    assign locked     = locked_q;
    assign outlier    = outlier_q;
endmodule

// File: doc/period_tracker.md
PERIOD_TRACKER -- requirements
Module: period_tracker

Interface
REQ-001 Parameter W, 12, edge timestamp and period width (6 int / W-6 frac at W=12).
REQ-002 Parameter G, 8, guard fraction bits in the filter datapath.
REQ-003 Parameter ACQ_ALPHA, 1, maximum alpha applied while in ACQ.
REQ-004 Parameter LOCK_CNT, 4, accepted samples in ACQ before TRACK (range 1..15).
REQ-005 Parameter TOL_SH, 2, outlier tolerance = stored value >> TOL_SH.
REQ-006 Parameter MAX_REJ, 3, consecutive outlier-condition samples that force re-acquire (range 1..7).
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 edge_valid  in  1  edge pair qualifier, sampled on posedge clk.
REQ-010 edge_rise  in  W  rise timestamp.
REQ-011 edge_fall  in  W  fall timestamp.
REQ-012 alpha  in  3  filter shift 0..7 (0 = replace).
REQ-013 ovr_en  in  1  period override select.
REQ-014 ovr_period  in  W  override value.
REQ-015 r2f, f2r  out  W each  filtered rise-to-fall / fall-to-rise half periods, registered.
REQ-016 eff_period  out  W  effective period.
REQ-017 eff_valid  out  1  one-cycle pulse, registered.
REQ-018 locked  out  1  high in TRACK, registered.
REQ-019 outlier  out  1  one-cycle rejection pulse, registered.

Function
REQ-020 Only cycles with edge_valid=1 update state; other cycles hold all registers and clear eff_valid/outlier.
REQ-021 Both timestamps zero: r2f=f2r=MID (1<<(W-1)), FSM->ACQ, counters cleared, eff_valid=0.
REQ-022 edge_fall>edge_rise: d=edge_fall-edge_rise updates r2f only; otherwise d=edge_rise-edge_fall updates f2r only (equal nonzero timestamps -> f2r with d=0).
REQ-023 Filter, width W+G: acc=cur<<G; new=((d<<G)>>a)+acc-(acc>>a); result=new[W+G-1:G]+new[G-1], saturated to all-ones on carry.
REQ-024 Effective shift a=min(alpha,ACQ_ALPHA) in ACQ, a=alpha in TRACK.
REQ-025 Latency: updated r2f/f2r and eff_valid=1 in the cycle after the accepted edge_valid.
REQ-026 FSM states ACQ, TRACK; ACQ counts accepted samples, entering TRACK on the LOCK_CNT-th, locked=1 from the following cycle.
REQ-027 eff_period=ovr_period when ovr_en=1, else r2f+f2r saturated to all-ones (combinational from registers).
REQ-028 ovr_en does not inhibit filter updates, FSM or flags.

Reset
REQ-029 rst asserted at any time, mid-sample included: r2f=f2r=MID, FSM=ACQ, counters=0, eff_valid=locked=outlier=0, immediately and asynchronously.
REQ-030 First edge_valid after rst deassertion is processed normally.

Configuration
REQ-031 PERIOD_TRACKER_OUTLIER_EN defined: in TRACK, sample with |d-cur|>cur>>TOL_SH is rejected (target unchanged, outlier=1 next cycle, reject counter+1); accepted sample clears the counter.
REQ-032 With the macro, the MAX_REJ-th consecutive outlier-condition sample is accepted with ACQ_ALPHA, FSM->ACQ, locked=0 and outlier=0 next cycle, counters cleared.
REQ-033 Without the macro: no rejection logic, all samples accepted, outlier tied 0.

Verification (W=12, G=8, defaults)
REQ-034 Reset -> r2f=f2r=0x800, eff_period=0xFFF (saturated), locked=0, eff_valid=0.
REQ-035 alpha=0, rise=0x100, fall=0x300, one valid -> next cycle r2f=0x200, f2r=0x800, eff_valid=1.
REQ-036 From reset, ACQ, alpha=2, rise=0x000, fall=0x400 -> r2f=0x600 (ACQ_ALPHA clamp).
REQ-037 4 valid nonzero samples -> locked=1 after 4th; then rise=fall=0 valid -> locked=0, r2f=f2r=0x800.
REQ-038 Macro on, TRACK with r2f=0x200, d=0x400 -> outlier=1, r2f=0x200 for 2 samples; 3rd -> accepted with a=1, r2f=0x300, locked=0.
REQ-039 ovr_en=1, ovr_period=0x123 -> eff_period=0x123 same cycle while r2f/f2r keep updating.
